alu_cmd_ctrl: RTL

- Upstream command/operand stage for the 4-bit ALU. Owns a small 4-bit register file.
- Accepts one command at a time over a valid/ready interface and drives registered A/B/sel to the ALU.
- Captures the ALU's combinational result/carry/zero, writes the result back to the register file, and returns a response over a valid/ready interface.

---
 rtl/alu_cmd_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command/operand controller in front of a 4-bit combinational ALU.
// Owns a small register file, issues one command at a time (IDLE -> EXEC -> RESP),
// writes the ALU result (or a load immediate) back and returns a response.
// Optional build macro ALU_CMD_CTRL_STICKY_EN adds a sticky carry flag with a clear input.
module alu_cmd_ctrl #(
  parameter int unsigned RF_DEPTH = 4,
  parameter int unsigned RF_AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  // Command interface
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [2:0]       cmd_sel,
  input  logic [RF_AW-1:0] cmd_rd,
  input  logic [RF_AW-1:0] cmd_rs1,
  input  logic [RF_AW-1:0] cmd_rs2,
  input  logic [3:0]       cmd_imm,
  // ALU operand side (registered)
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  // ALU result side (combinational from alu_a/alu_b/alu_sel)
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  // Response interface
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
`ifdef ALU_CMD_CTRL_STICKY_EN
  input  logic             sticky_clr,
  output logic             sticky_carry,
`endif
  // Debug read port
  input  logic [RF_AW-1:0] dbg_addr,
  output logic [3:0]       dbg_data
);

  // Address width must cover the register file exactly.
  if (RF_AW != $clog2(RF_DEPTH)) begin : gen_param_check
    $error("alu_cmd_ctrl: RF_AW must equal log2(RF_DEPTH)");
  end

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       rf_q [RF_DEPTH];
  logic             ld_q;
  logic [RF_AW-1:0] rd_q;
  logic [3:0]       imm_q;

  logic             accept;
  logic             exec;
  logic             rsp_fire;
  logic [3:0]       wr_data;
  logic             wr_carry;
  logic             wr_zero;

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;
  assign exec      = (state_q == StExec);
  assign rsp_fire  = (state_q == StResp) && rsp_valid && rsp_ready;

  // Next-state logic: fixed one-cycle EXEC, RESP waits for the response handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write-back value: immediate for loads, ALU outputs passed through otherwise.
  always_comb begin
    wr_data  = alu_result;
    wr_carry = alu_carry;
    wr_zero  = alu_zero;
    if (ld_q) begin
      wr_data  = imm_q;
      wr_carry = 1'b0;
      wr_zero  = (imm_q == 4'd0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture and operand issue; operands read the file before any write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q    <= 1'b0;
      rd_q    <= '0;
      imm_q   <= 4'd0;
      alu_a   <= 4'd0;
      alu_b   <= 4'd0;
      alu_sel <= 3'd0;
    end else if (accept) begin
      ld_q    <= cmd_ld;
      rd_q    <= cmd_rd;
      imm_q   <= cmd_imm;
      alu_a   <= rf_q[cmd_rs1];
      alu_b   <= rf_q[cmd_rs2];
      alu_sel <= cmd_sel;
    end
  end

  // Register file: single write port, written only on the EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) begin
        rf_q[i] <= 4'd0;
      end
    end else if (exec) begin
      rf_q[rd_q] <= wr_data;
    end
  end

  // Response register: loaded on EXEC, held through RESP until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 4'd0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else if (exec) begin
      rsp_valid <= 1'b1;
      rsp_data  <= wr_data;
      rsp_carry <= wr_carry;
      rsp_zero  <= wr_zero;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_CMD_CTRL_STICKY_EN
  // Sticky carry: set by any ALU op producing carry; set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry <= 1'b0;
    end else if (exec && !ld_q && alu_carry) begin
      sticky_carry <= 1'b1;
    end else if (sticky_clr) begin
      sticky_carry <= 1'b0;
    end
  end
`endif

  assign dbg_data = rf_q[dbg_addr];

endmodule
